// File: rtl/reg_file_ctrl_pkg.sv
// Shared types for the register-file controller.
// Build option REG_BYPASS_EN: answer in-flight writes from bypass registers.
package reg_file_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_PEND  = 2'd2
   } state_t;

   localparam int REG_ZERO_ADDR = 0;

endpackage

// File: rtl/reg_clr_seq.sv
// Post-reset zero-fill sequencer: walks port A over every register while active.
// Raises done on the last address.
module reg_clr_seq #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              active,
   output logic              done,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [DATA_W-1:0] dina
);

   logic [ADDR_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             cnt <= '0;
      else if (!active || done) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
   end

   assign done  = active && (cnt == ADDR_W'(DEPTH - 1));
   assign wea   = 1'b1;
   assign addra = cnt;
   assign dina  = '0;

endmodule

// File: rtl/reg_file_ctrl.sv
// Register-file controller in front of a 1R1W + 1R block RAM with registered reads.
// Build option REG_BYPASS_EN: writes that overlap an outstanding read feed bypass registers.
module reg_file_ctrl
   import reg_file_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   output logic              ready,
   input  logic              rd_req,
   output logic              rd_rdy,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic              rd_vld,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              bram_wea,
   output logic [ADDR_W-1:0] bram_addra,
   output logic [DATA_W-1:0] bram_dina,
   input  logic [DATA_W-1:0] bram_douta,
   output logic [ADDR_W-1:0] bram_addrb,
   input  logic [DATA_W-1:0] bram_doutb
);

   state_t            state, state_nxt;
   logic              clr_done, clr_wea;
   logic [ADDR_W-1:0] clr_addra;
   logic [DATA_W-1:0] clr_dina;
   logic [ADDR_W-1:0] rs_lat, rt_lat;
   logic              rs_zero, rt_zero;
   logic              accept, wr_ok, fetch;
   logic [DATA_W-1:0] rs_src, rt_src;

   reg_clr_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .active (state == ST_CLEAR),
      .done   (clr_done),
      .wea    (clr_wea),
      .addra  (clr_addra),
      .dina   (clr_dina)
   );

   assign ready  = (state != ST_CLEAR);
   assign rd_rdy = (state == ST_IDLE);
   assign accept = rd_req && rd_rdy;
   assign wr_ok  = wr_req && (wr_addr != ADDR_W'(REG_ZERO_ADDR));
   // Port reads of this cycle complete the operand fetch, so rd_vld follows.
   assign fetch  = !wr_req && (accept || state == ST_PEND);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= ST_CLEAR;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      bram_wea   = 1'b0;
      bram_addra = rs_addr;
      bram_dina  = wr_data;
      bram_addrb = rt_addr;
      case (state)
         ST_CLEAR: begin
            bram_wea   = clr_wea;
            bram_addra = clr_addra;
            bram_dina  = clr_dina;
            bram_addrb = '0;
            if (clr_done) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (wr_req) begin
               bram_wea   = wr_ok;
               bram_addra = wr_addr;
               if (accept) state_nxt = ST_PEND;
            end
         end
         ST_PEND: begin
            // Port B stays on rt so the replay cycle also refreshes it.
            bram_addrb = rt_lat;
            if (wr_req) begin
               bram_wea   = wr_ok;
               bram_addra = wr_addr;
            end else begin
               bram_addra = rs_lat;
               state_nxt  = ST_IDLE;
            end
         end
         default: state_nxt = ST_CLEAR;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_vld  <= 1'b0;
         rs_lat  <= '0;
         rt_lat  <= '0;
         rs_zero <= 1'b0;
         rt_zero <= 1'b0;
      end else begin
         rd_vld <= fetch;
         if (accept) begin
            rs_lat  <= rs_addr;
            rt_lat  <= rt_addr;
            rs_zero <= (rs_addr == ADDR_W'(REG_ZERO_ADDR));
            rt_zero <= (rt_addr == ADDR_W'(REG_ZERO_ADDR));
         end
      end
   end

`ifdef REG_BYPASS_EN
   logic              rs_byp_vld, rt_byp_vld;
   logic [DATA_W-1:0] rs_byp, rt_byp;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rs_byp_vld <= 1'b0;
         rt_byp_vld <= 1'b0;
         rs_byp     <= '0;
         rt_byp     <= '0;
      end else if (accept) begin
         rs_byp_vld <= 1'b0;
         rt_byp_vld <= wr_ok && (wr_addr == rt_addr);
         rt_byp     <= wr_data;
      end else if (state == ST_PEND && wr_ok) begin
         if (wr_addr == rs_lat) begin
            rs_byp_vld <= 1'b1;
            rs_byp     <= wr_data;
         end
         if (wr_addr == rt_lat) begin
            rt_byp_vld <= 1'b1;
            rt_byp     <= wr_data;
         end
      end
   end

   assign rs_src = rs_byp_vld ? rs_byp : bram_douta;
   assign rt_src = rt_byp_vld ? rt_byp : bram_doutb;
`else
   assign rs_src = bram_douta;
   assign rt_src = bram_doutb;
`endif

   assign rs_data = (rd_vld && !rs_zero) ? rs_src : '0;
   assign rt_data = (rd_vld && !rt_zero) ? rt_src : '0;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Randomised bench for reg_file_ctrl against a behavioural register-file model,
// with a read-first dual-port RAM model attached to the BRAM ports.
module tb_reg_file_ctrl;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n = 1'b0;
   logic              ready, rd_req, rd_rdy, rd_vld, wr_req, bram_wea;
   logic [ADDR_W-1:0] rs_addr, rt_addr, wr_addr, bram_addra, bram_addrb;
   logic [DATA_W-1:0] rs_data, rt_data, wr_data, bram_dina, bram_douta, bram_doutb;

   reg_file_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .ready      (ready),
      .rd_req     (rd_req),
      .rd_rdy     (rd_rdy),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rd_vld     (rd_vld),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .bram_wea   (bram_wea),
      .bram_addra (bram_addra),
      .bram_dina  (bram_dina),
      .bram_douta (bram_douta),
      .bram_addrb (bram_addrb),
      .bram_doutb (bram_doutb)
   );

   always #5 sys_clk = ~sys_clk;

   // RAM model: registered read-first outputs; seed_mem fills it with garbage.
   logic [DATA_W-1:0] mem [DEPTH];
   logic              seed_mem = 1'b1;
   always @(posedge sys_clk) begin
      if (seed_mem) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEADBEEF;
      end else if (bram_wea) begin
         mem[bram_addra] <= bram_dina;
      end
      bram_douta <= mem[bram_addra];
      bram_doutb <= mem[bram_addrb];
   end

   // Reference model: architectural registers plus the read protocol.
   logic [DATA_W-1:0] regs [DEPTH];
   int                m_clr;
   bit                m_pend, m_vld;
   logic [ADDR_W-1:0] m_prs, m_prt;
   logic [DATA_W-1:0] m_rs, m_rt;
   int                n_chk = 0;
   int                n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [DATA_W-1:0] rv(input logic [ADDR_W-1:0] i);
      return (i == 0) ? '0 : regs[i];
   endfunction

   task automatic model_edge();
      bit up, acc;
      up  = (m_clr == 0);
      acc = rd_req && up && !m_pend;
      m_vld = 1'b0;
      if (up && wr_req && wr_addr != 0) regs[wr_addr] = wr_data;
      if (acc && !wr_req) begin
         m_vld = 1'b1;
         m_rs  = rv(rs_addr);
         m_rt  = rv(rt_addr);
      end else if (acc) begin
         m_pend = 1'b1;
         m_prs  = rs_addr;
         m_prt  = rt_addr;
      end else if (m_pend && !wr_req) begin
         m_pend = 1'b0;
         m_vld  = 1'b1;
         m_rs   = rv(m_prs);
         m_rt   = rv(m_prt);
      end
      if (m_clr > 0) m_clr--;
   endtask

   task automatic check_cycle();
      chk("ready", 32'(ready), 32'(m_clr == 0));
      chk("rd_rdy", 32'(rd_rdy), 32'(m_clr == 0 && !m_pend));
      chk("rd_vld", 32'(rd_vld), 32'(m_vld));
      chk("rs_data", rs_data, m_vld ? m_rs : 32'h0);
      chk("rt_data", rt_data, m_vld ? m_rt : 32'h0);
      if (m_clr != 0) begin
         chk("clr_wea", 32'(bram_wea), 32'd1);
         chk("clr_dina", bram_dina, 32'h0);
      end
   endtask

   // One clock: drive inputs, check port A/B usage, advance model, check outputs.
   task automatic cyc(input logic w, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic r, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] ta);
      wr_req = w; wr_addr = wa; wr_data = wd;
      rd_req = r; rs_addr = ra; rt_addr = ta;
      #1;
      if (m_clr == 0 && w) begin
         chk("wr_wea", 32'(bram_wea), 32'(wa != 0));
         if (wa != 0) begin
            chk("wr_addra", 32'(bram_addra), 32'(wa));
            chk("wr_dina", bram_dina, wd);
         end
      end else if (m_clr == 0 && r && !m_pend) begin
         chk("rd_wea", 32'(bram_wea), 32'd0);
         chk("rd_addra", 32'(bram_addra), 32'(ra));
         chk("rd_addrb", 32'(bram_addrb), 32'(ta));
      end
      model_edge();
      @(posedge sys_clk);
      #1;
      check_cycle();
   endtask

   task automatic cyc_rand();
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      wr_req = 1'b0; rd_req = 1'b0;
      @(posedge sys_clk);
      #1;
      chk("rst_vld", 32'(rd_vld), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_rdy", 32'(rd_rdy), 32'd0);
      chk("rst_wea", 32'(bram_wea), 32'd1);
      chk("rst_addra", 32'(bram_addra), 32'd0);
      chk("rst_addrb", 32'(bram_addrb), 32'd0);
      chk("rst_dina", bram_dina, 32'h0);
      chk("rst_rs", rs_data, 32'h0);
      chk("rst_rt", rt_data, 32'h0);
      m_clr = DEPTH; m_pend = 1'b0; m_vld = 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] = '0;
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
   endtask

   initial begin
      wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; wr_data = '0; rs_addr = '0; rt_addr = '0;
      do_reset();
      seed_mem = 1'b0;

      // Clear window: everything driven now must be ignored.
      for (int i = 0; i < DEPTH; i++) cyc_rand();
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, '0, 1'b1, 5'(i), 5'(DEPTH - 1 - i));
      idle(1);

      // Write then read on the next cycle; write to $zero then read it.
      cyc(1'b1, 5'd1, 32'h1111, 1'b0, '0, '0);
      cyc(1'b0, '0, '0, 1'b1, 5'd1, 5'd0);
      idle(1);
      cyc(1'b1, 5'd0, 32'h5555, 1'b0, '0, '0);
      cyc(1'b0, '0, '0, 1'b1, 5'd0, 5'd0);
      idle(1);

      // Read colliding with a same-cycle write to rt.
      cyc(1'b1, 5'd3, 32'h4444, 1'b0, '0, '0);
      cyc(1'b1, 5'd2, 32'h3333, 1'b1, 5'd3, 5'd2);
      idle(2);

      // Read-with-write followed by three back-to-back writes.
      cyc(1'b1, 5'd4, 32'hA0A0, 1'b1, 5'd4, 5'd5);
      cyc(1'b1, 5'd5, 32'hB1B1, 1'b1, 5'd6, 5'd6);
      cyc(1'b1, 5'd6, 32'hC2C2, 1'b1, 5'd6, 5'd6);
      cyc(1'b1, 5'd4, 32'hD3D3, 1'b0, '0, '0);
      idle(2);

      // Reset while a read is parked.
      cyc(1'b1, 5'd7, 32'h7777, 1'b1, 5'd7, 5'd1);
      cyc(1'b1, 5'd1, 32'h1234, 1'b0, '0, '0);
      do_reset();
      for (int i = 0; i < DEPTH; i++) cyc_rand();
      cyc(1'b0, '0, '0, 1'b1, 5'd7, 5'd1);
      idle(1);

      for (int i = 0; i < 1500; i++) cyc_rand();
      idle(3);
      chk("mem0", mem[0], 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
